// File: rtl/nios2_cpu_div_cell_if.sv
// Execute-stage divide handshake: operands and controls in, results and status out.
interface nios2_cpu_div_cell_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] E_src1;
   logic [DATA_WIDTH-1:0] E_src2;
   logic                  div_start;
   logic                  div_signed;
   logic                  div_abort;
   logic [DATA_WIDTH-1:0] div_quotient;
   logic [DATA_WIDTH-1:0] div_remainder;
   logic                  div_busy;
   logic                  div_done;

   modport master (
      output E_src1, E_src2, div_start, div_signed, div_abort,
      input  div_quotient, div_remainder, div_busy, div_done
   );

   modport slave (
      input  E_src1, E_src2, div_start, div_signed, div_abort,
      output div_quotient, div_remainder, div_busy, div_done
   );
endinterface

// File: rtl/nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a sign-fix cycle and flush abort.
//   state | meaning
//   IDLE  | waiting for div_start; results held
//   CALC  | one quotient bit per cycle, DATA_WIDTH cycles
//   FIX   | apply signs / div-by-zero result, load outputs, pulse done next cycle
module nios2_cpu_div_cell #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   nios2_cpu_div_cell_if.slave   bus
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH:0]   part_rem;
   logic [DATA_WIDTH-1:0] quo;
   logic [DATA_WIDTH-1:0] divisor_mag;
   logic [DATA_WIDTH-1:0] dividend_raw;
   logic                  q_neg;
   logic                  r_neg;
   logic                  div_zero;
   logic [DATA_WIDTH-1:0] quotient_q;
   logic [DATA_WIDTH-1:0] remainder_q;
   logic                  done_q;

   logic                  start_ok;
   logic                  last_iter;
   logic                  src1_neg;
   logic                  src2_neg;
   logic [DATA_WIDTH-1:0] src1_mag;
   logic [DATA_WIDTH-1:0] src2_mag;
   logic [DATA_WIDTH:0]   rem_shift;
   logic [DATA_WIDTH:0]   trial;
   logic [DATA_WIDTH-1:0] q_fix;
   logic [DATA_WIDTH-1:0] r_fix;

   assign start_ok  = (state == IDLE) && bus.div_start && !bus.div_abort;
   assign last_iter = (count == CW'(DATA_WIDTH - 1));

   // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
   assign src1_neg = bus.div_signed & bus.E_src1[DATA_WIDTH-1];
   assign src2_neg = bus.div_signed & bus.E_src2[DATA_WIDTH-1];
   assign src1_mag = src1_neg ? -bus.E_src1 : bus.E_src1;
   assign src2_mag = src2_neg ? -bus.E_src2 : bus.E_src2;

   // The dividend is shifted out of quo's MSB as quotient bits shift in at the LSB.
   assign rem_shift = {part_rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
   assign trial     = rem_shift - {1'b0, divisor_mag};

   assign q_fix = q_neg ? -quo : quo;
   assign r_fix = r_neg ? -part_rem[DATA_WIDTH-1:0] : part_rem[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = CALC;
         CALC:    if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.div_abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         part_rem     <= '0;
         quo          <= '0;
         divisor_mag  <= '0;
         dividend_raw <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         div_zero     <= 1'b0;
         quotient_q   <= '0;
         remainder_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  count        <= '0;
                  part_rem     <= '0;
                  quo          <= src1_mag;
                  divisor_mag  <= src2_mag;
                  dividend_raw <= bus.E_src1;
                  q_neg        <= src1_neg ^ src2_neg;
                  r_neg        <= src1_neg;
                  div_zero     <= (bus.E_src2 == '0);
               end
            end
            CALC: begin
               part_rem <= trial[DATA_WIDTH] ? rem_shift : trial;
               quo      <= {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
               count    <= count + 1'b1;
            end
            FIX: begin
               if (!bus.div_abort) begin
                  if (div_zero) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend_raw;
                  end else begin
                     quotient_q  <= q_fix;
                     remainder_q <= r_fix;
                  end
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.div_quotient  = quotient_q;
   assign bus.div_remainder = remainder_q;
   assign bus.div_busy      = (state != IDLE);
   assign bus.div_done      = done_q;
endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Scoreboard bench for nios2_cpu_div_cell: directed corner cases, handshake/abort/reset, random ops.
module tb_nios2_cpu_div_cell;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks_total = 0;
   int   checks_passed = 0;

   nios2_cpu_div_cell_if #(.DATA_WIDTH(32)) bus ();

   nios2_cpu_div_cell #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          due;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: plain integer division, truncating toward zero; divisor zero gives all-ones / dividend.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sbv, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         lq  = sa / sbv;
         lr  = sa % sbv;
         q   = lq[31:0];
         r   = lr[31:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   always @(negedge clk) begin
      if (bus.div_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_quotient"}, bus.div_quotient, mon_e.q);
            chk({mon_e.name, "_remainder"}, bus.div_remainder, mon_e.r);
            chk({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
         end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
         mon_e = sb.pop_front();
         chk({mon_e.name, "_done_timeout"}, 32'd0, 32'd1);
      end
   end

   // Called just after a rising edge; returns just after the edge that sampled the start.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input string nm);
      bus.E_src1     = a;
      bus.E_src2     = b;
      bus.div_signed = s;
      bus.div_start  = 1'b1;
      @(posedge clk); #1;
      bus.div_start  = 1'b0;
      bus.E_src1     = $urandom;
      bus.E_src2     = $urandom;
      bus.div_signed = 1'($urandom);
      sb.push_back('{eq, er, cyc + 33, nm});
      last_q = eq;
      last_r = er;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t dir[$];

   initial begin
      int          busy_bad;
      int          n0;
      logic [31:0] hold_q, hold_r, ra, rb, eq, er;
      logic        rs;

      reset          = 1'b1;
      bus.E_src1     = '0;
      bus.E_src2     = '0;
      bus.div_start  = 1'b0;
      bus.div_signed = 1'b0;
      bus.div_abort  = 1'b0;
      step(3);
      chk("reset_quotient", bus.div_quotient, 32'd0);
      chk("reset_remainder", bus.div_remainder, 32'd0);
      chk("reset_busy", 32'(bus.div_busy), 32'd0);
      chk("reset_done", 32'(bus.div_done), 32'd0);
      reset = 1'b0;
      step(2);

      // 100/7 with busy-window check
      start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
      busy_bad = 0;
      for (int i = 0; i < 33; i++) begin
         if (bus.div_busy !== 1'b1) busy_bad++;
         step(1);
      end
      chk("busy_33_cycles", 32'(busy_bad), 32'd0);
      chk("busy_low_at_done", 32'(bus.div_busy), 32'd0);

      dir.push_back('{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
      dir.push_back('{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001});
      dir.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000});
      dir.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000});
      dir.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678});
      dir.push_back('{32'h1234_5678, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678});
      dir.push_back('{32'h8000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000});
      foreach (dir[i]) begin
         start_op(dir[i].a, dir[i].b, dir[i].s, dir[i].q, dir[i].r, $sformatf("dir%0d", i));
         step(33);
      end

      // Second start while busy is ignored
      start_op(32'h0000_1000, 32'h0000_0010, 1'b0, 32'h0000_0100, 32'd0, "start_while_busy");
      step(4);
      bus.E_src1    = 32'd99;
      bus.E_src2    = 32'd9;
      bus.div_start = 1'b1;
      step(1);
      bus.div_start = 1'b0;
      step(28);

      // Abort mid-calculation
      hold_q = last_q;
      hold_r = last_r;
      start_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, "aborted");
      n0 = cyc;
      step(9);
      bus.div_abort = 1'b1;
      step(1);
      bus.div_abort = 1'b0;
      chk("abort_busy_drop", 32'(bus.div_busy), 32'd0);
      chk("abort_cycle", 32'(cyc - n0), 32'd10);
      void'(sb.pop_back());
      last_q = hold_q;
      last_r = hold_r;
      step(30);
      chk("abort_hold_quotient", bus.div_quotient, hold_q);
      chk("abort_hold_remainder", bus.div_remainder, hold_r);
      start_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "after_abort_50_5");
      step(33);

      // Reset mid-operation
      start_op(32'hDEAD_BEEF, 32'd17, 1'b0, 32'hDEAD_BEEF / 32'd17, 32'hDEAD_BEEF % 32'd17, "reset_mid");
      step(19);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      void'(sb.pop_back());
      chk("midreset_quotient", bus.div_quotient, 32'd0);
      chk("midreset_remainder", bus.div_remainder, 32'd0);
      chk("midreset_busy", 32'(bus.div_busy), 32'd0);
      chk("midreset_done", 32'(bus.div_done), 32'd0);
      step(2);

      // Abort and start together in IDLE: nothing starts
      bus.E_src1    = 32'd77;
      bus.E_src2    = 32'd7;
      bus.div_start = 1'b1;
      bus.div_abort = 1'b1;
      step(1);
      bus.div_start = 1'b0;
      bus.div_abort = 1'b0;
      chk("abort_start_no_busy", 32'(bus.div_busy), 32'd0);
      step(40);
      chk("abort_start_outputs_kept", bus.div_quotient, 32'd0);

      // Random back-to-back operations
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'($urandom_range(0, 15));
            1:       rb = -32'($urandom_range(1, 15));
            2:       rb = ra >> $urandom_range(1, 31);
            default: rb = $urandom;
         endcase
         rs = 1'($urandom);
         model(ra, rb, rs, eq, er);
         start_op(ra, rb, rs, eq, er, $sformatf("rnd%0d", i));
         step(33);
      end

      step(5);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule

// File: doc/nios2_cpu_div_cell.md
# nios2_cpu_div_cell

Iterative 32-bit integer divider for the Nios II CPU execute stage: the divide counterpart of the pipelined 16x16 partial-product multiply cell. Accepts dividend/divisor from the E stage on a start pulse, runs a radix-2 restoring division over 32 iterations plus a sign-fix cycle, and returns quotient and remainder with a single-cycle done pulse. Supports signed (div) and unsigned (divu) operation and a pipeline-flush abort.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- E_src1  in  32  dividend, sampled on accepted start
- E_src2  in  32  divisor, sampled on accepted start
- div_start  in  1  start request; accepted only in IDLE
- div_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- div_abort  in  1  pipeline flush; cancels any operation
- div_quotient  out  32  quotient, registered, held until next accepted start completes
- div_remainder  out  32  remainder, registered, held likewise
- div_busy  out  1  high while an operation is in progress
- div_done  out  1  one-cycle pulse, results valid

## Operation
- Reset (synchronous, active-high): state IDLE, div_quotient=0, div_remainder=0, div_busy=0, div_done=0, iteration counter=0.
- States: IDLE -> CALC (start accepted) -> FIX (counter reaches 31) -> IDLE (done pulsed).
- IDLE: on div_start=1 and div_abort=0, capture operands and div_signed; convert operands to magnitudes when signed (|0x80000000| = 0x80000000 as unsigned); record q_neg = sign1 XOR sign2 and r_neg = sign1 (signed mode only); also record div-by-zero flag (E_src2==0).
- CALC: per cycle shift partial remainder left, bring in the next dividend MSB, trial-subtract divisor magnitude; if no borrow, keep the difference and set quotient bit to 1, otherwise restore and set 0. Partial remainder is 33 bits wide to hold the borrow.
- FIX: negate quotient if q_neg, negate remainder if r_neg; load output registers; assert div_done for the following cycle.
- Divide by zero (either mode): div_quotient=0xFFFFFFFF, div_remainder=raw E_src1; same latency as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: falls out of the algorithm as quotient 0x80000000, remainder 0; no exception.
- div_start while busy: ignored; operands not re-sampled.
- div_abort: in any state, next state IDLE, div_busy=0, no div_done, output registers keep their previous values. Abort and start in the same IDLE cycle: abort wins, start dropped.
- Reset mid-operation: same as reset above; outputs cleared to 0.

## Timing
- Start sampled at edge N (state IDLE).
- div_busy=1 for cycles N+1 .. N+33 (32 CALC + 1 FIX).
- div_done=1 for exactly cycle N+34; div_quotient/div_remainder valid from N+34 and stable until the next completion.
- div_busy=0 at N+34; a new div_start in cycle N+34 is accepted (back-to-back throughput one op per 34 cycles).
- No combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, div_signed=0 -> div_done exactly 34 cycles after start; quotient 14, remainder 2; busy high 33 cycles.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- Corner cases: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide by zero 0x12345678 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 0x12345678 after 34 cycles.
- Handshake: second div_start at cycle N+5 with different operands -> ignored, first result returned; div_abort at N+10 -> busy drops at N+11, no done; then start 50/5 -> quotient 10, remainder 0.
- Reset asserted at N+20 -> all outputs 0 next cycle, no done; abort+start same cycle in IDLE -> no operation begins.
